sky130_fd_io__sio_cfg_seq: RTL and testbench
============================================

Name: sky130_fd_io__sio_cfg_seq

Overview:
- Synchronous core-side sequencer that owns every control input of one SIO pad: ENABLE_H, HLD_H_N, HLD_OVR, DM, OE_N, OUT, SLOW, VTRIP_SEL, INP_DIS, IBUF_SEL and VREG_EN.
- Enforces glitch-free ordering on the pad: tristate before a mode change, settle before hold entry and exit, safe defaults before enable and disable.
- Rejects illegal regulated-output configurations.
- Sits between the GPIO configuration registers and the pad cell.

Parameters:
SETTLE_CYC, 4, cycles each intermediate step is held stable (legal range 1..255)
ENABLE_CYC, 8, cycles after ENABLE_H rises before the first configuration is accepted (legal range 1..255)

Ports:
CLK  input  1  clock
RESET  input  1  reset, synchronous, active-high
EN_REQ  input  1  level request to enable the pad
CFG_VALID  input  1  new configuration offered
CFG_READY  output  1  configuration accepted on a cycle where CFG_VALID and CFG_READY are both 1
CFG_DM  input  3  requested drive mode
CFG_OE_N, CFG_SLOW, CFG_VTRIP_SEL, CFG_INP_DIS, CFG_IBUF_SEL, CFG_VREG_EN  input  1 each  requested field values
REF_GOOD  input  1  VOUTREF and REFLEAK_BIAS are valid
OUT_REQ  input  1  core output data
HOLD_REQ  input  1  level request to enter hold
HOLD_OVR_REQ  input  1  allow OE_N/OUT updates while in hold
ENABLE_H, HLD_H_N, HLD_OVR, OE_N, OUT, SLOW, VTRIP_SEL, INP_DIS, IBUF_SEL, VREG_EN  output  1 each  pad controls
DM  output  3  pad drive mode
HOLD_ACK  output  1  pad is latched in hold
CFG_ERR  output  1  one-cycle pulse on a rejected configuration
BUSY  output  1  high in any transitional state

Behaviour:
- Output registers:
  - All pad outputs are registered.
  - CFG_READY is combinational: state==ACTIVE && EN_REQ && !HOLD_REQ.
  - BUSY is combinational: high in any state other than OFF, ACTIVE or HOLD.
- Reset: on the RESET edge, state goes to OFF, counter clears, and any sequence in progress is aborted. Output values after reset:
  - ENABLE_H=0, HLD_H_N=1, HLD_OVR=0.
  - DM=000, OE_N=1, OUT=0, INP_DIS=1.
  - SLOW, VTRIP_SEL, IBUF_SEL, VREG_EN all 0.
  - HOLD_ACK=0, CFG_ERR=0.
  - Shadow registers take the same safe values.
- Counter: one down-counter, loaded with N-1 on entering a timed state; the state exits when the counter reaches 0. A timed state therefore lasts exactly N cycles.
- States:
  - OFF: EN_REQ=1 -> ENABLING; ENABLE_H=1 from the next cycle.
  - ENABLING (ENABLE_CYC cycles) -> ACTIVE. DM stays 000, OE_N=1.
  - ACTIVE, evaluated in priority order:
    - EN_REQ=0 -> DISABLING.
    - Otherwise HOLD_REQ=1 -> HOLD_SETUP.
    - Otherwise an accepted config is checked. It is illegal if CFG_VREG_EN=1 and either CFG_DM is not one of 011, 101 or 110, or REF_GOOD=0.
    - Illegal: CFG_ERR=1 for one cycle, no field changes, stay in ACTIVE.
    - Legal: capture into shadow -> TRI.
  - TRI (SETTLE_CYC cycles): OE_N=1.
  - APPLY (SETTLE_CYC cycles): DM, SLOW, VTRIP_SEL, INP_DIS, IBUF_SEL, VREG_EN take shadow values on the first cycle; OE_N stays 1.
  - RELEASE (1 cycle): OE_N=shadow OE_N -> ACTIVE.
  - Configuration latency: accepted at edge t gives OE_N=1 at t+1, fields at t+1+S, final OE_N at t+1+2S, CFG_READY at t+2+2S.
  - HOLD_SETUP (SETTLE_CYC cycles, all outputs frozen) -> HOLD. HLD_H_N=0 and HOLD_ACK=1 from entry.
  - HOLD:
    - HLD_OVR follows HOLD_OVR_REQ, registered.
    - OUT tracks OUT_REQ only while HLD_OVR=1; otherwise OUT is frozen.
    - HOLD_REQ=0 -> HOLD_EXIT.
    - EN_REQ=0 and CFG_VALID are ignored in HOLD.
  - HOLD_EXIT (SETTLE_CYC cycles): HLD_OVR=0; all other outputs are re-driven from shadow and the OUT_REQ capture; HLD_H_N stays 0. On exit, HLD_H_N=1 and HOLD_ACK=0 -> ACTIVE.
  - DISABLING (SETTLE_CYC cycles): OE_N=1, DM=000, INP_DIS=1. On exit, ENABLE_H=0 -> OFF. Shadow is reset to safe values.
- OUT: registered copy of OUT_REQ (1-cycle latency) in ACTIVE, TRI, APPLY and RELEASE; frozen in all other states, except HOLD with HLD_OVR=1.
- Requests that arrive while BUSY are not lost if held: EN_REQ and HOLD_REQ are levels and are re-evaluated on return to ACTIVE.
- CFG_VALID arriving on the same cycle as HOLD_REQ or EN_REQ=0 is not accepted (CFG_READY=0).
- Counter width is 8 bits.
- RESET asserted mid-hold releases hold immediately (HLD_H_N=1, ENABLE_H=0 on the same edge).

Test Plan:
- Power-up, S=4, E=8: RESET edge 0 then deasserted; EN_REQ=1 sampled at edge 2 -> ENABLE_H=1 at cycle 3, CFG_READY=1 at cycle 11, DM=000, OE_N=1 throughout.
- Legal config DM=110, OE_N=0, VREG_EN=1, REF_GOOD=1, accepted at edge t -> OE_N=1 at t+1, DM=110 and VREG_EN=1 at t+5, OE_N=0 at t+9, CFG_READY=1 at t+10.
- Illegal config DM=010, VREG_EN=1 -> CFG_ERR high exactly 1 cycle; DM/OE_N unchanged; CFG_READY stays 1. Repeat with DM=011 and REF_GOOD=0 -> same result.
- Hold, S=4: HOLD_REQ=1 at edge t -> HLD_H_N=0 at t+5. With HOLD_OVR_REQ=1, toggling OUT_REQ toggles OUT; with HLD_OVR=0, OUT is frozen. HOLD_REQ=0 -> HLD_H_N=1 four cycles after HOLD_EXIT entry.
- Disable while configuring: EN_REQ=0 during APPLY -> sequence completes, then DISABLING; ENABLE_H=0 after 4 cycles with DM=000, OE_N=1.
- RESET pulsed in TRI and in HOLD -> next cycle all outputs at reset values, state OFF, HOLD_ACK=0, BUSY=0.

Source files
------------

// File: rtl/sky130_fd_io__sio_cfg_seq_if.sv
// Configuration handshake between the GPIO configuration registers and the SIO pad sequencer.
interface sky130_fd_io__sio_cfg_seq_if;
    logic       valid;
    logic       ready;
    logic [2:0] dm;
    logic       oe_n;
    logic       slow;
    logic       vtrip_sel;
    logic       inp_dis;
    logic       ibuf_sel;
    logic       vreg_en;

    modport master (
        output valid, dm, oe_n, slow, vtrip_sel, inp_dis, ibuf_sel, vreg_en,
        input  ready
    );

    modport slave (
        input  valid, dm, oe_n, slow, vtrip_sel, inp_dis, ibuf_sel, vreg_en,
        output ready
    );
endinterface

// File: rtl/sky130_fd_io__sio_cfg_seq.sv
// Core-side sequencer for one SIO pad: orders enable, reconfiguration, hold and disable so the
// pad never sees a glitching or illegal control combination.
module sky130_fd_io__sio_cfg_seq #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned ENABLE_CYC = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    sky130_fd_io__sio_cfg_seq_if.slave cfg_io,
    input  logic                       en_req_i,
    input  logic                       ref_good_i,
    input  logic                       out_req_i,
    input  logic                       hold_req_i,
    input  logic                       hold_ovr_req_i,
    output logic                       enable_h_o,
    output logic                       hld_h_n_o,
    output logic                       hld_ovr_o,
    output logic [2:0]                 dm_o,
    output logic                       oe_n_o,
    output logic                       out_o,
    output logic                       slow_o,
    output logic                       vtrip_sel_o,
    output logic                       inp_dis_o,
    output logic                       ibuf_sel_o,
    output logic                       vreg_en_o,
    output logic                       hold_ack_o,
    output logic                       cfg_err_o,
    output logic                       busy_o
);

    typedef struct packed {
        logic [2:0] dm;
        logic       oe_n;
        logic       slow;
        logic       vtrip_sel;
        logic       inp_dis;
        logic       ibuf_sel;
        logic       vreg_en;
    } pad_cfg_t;

    typedef enum logic [3:0] {
        StOff,
        StEnabling,
        StActive,
        StTri,
        StApply,
        StRelease,
        StHoldSetup,
        StHold,
        StHoldExit,
        StDisabling
    } state_e;

    localparam pad_cfg_t SafeCfg = '{
        dm: 3'b000, oe_n: 1'b1, slow: 1'b0, vtrip_sel: 1'b0,
        inp_dis: 1'b1, ibuf_sel: 1'b0, vreg_en: 1'b0
    };
    localparam logic [7:0] SettleLd = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] EnableLd = 8'(ENABLE_CYC - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    pad_cfg_t   pad_q, pad_d;
    pad_cfg_t   shadow_q, shadow_d;
    logic       enable_h_q, enable_h_d;
    logic       hld_h_n_q, hld_h_n_d;
    logic       hld_ovr_q, hld_ovr_d;
    logic       out_q, out_d;
    logic       hold_ack_q, hold_ack_d;
    logic       cfg_err_q, cfg_err_d;

    pad_cfg_t   cfg_in;
    logic       cfg_legal;
    logic       timer_done;

    assign cfg_in = '{
        dm: cfg_io.dm, oe_n: cfg_io.oe_n, slow: cfg_io.slow, vtrip_sel: cfg_io.vtrip_sel,
        inp_dis: cfg_io.inp_dis, ibuf_sel: cfg_io.ibuf_sel, vreg_en: cfg_io.vreg_en
    };

    // The regulated output is only usable in its three supported drive modes with a valid reference.
    assign cfg_legal = !cfg_io.vreg_en ||
                       ((cfg_io.dm inside {3'b011, 3'b101, 3'b110}) && ref_good_i);

    assign timer_done   = (cnt_q == 8'd0);
    assign cfg_io.ready = (state_q == StActive) && en_req_i && !hold_req_i;
    assign busy_o       = !(state_q inside {StOff, StActive, StHold});

    always_comb begin
        state_d    = state_q;
        cnt_d      = timer_done ? cnt_q : cnt_q - 8'd1;
        pad_d      = pad_q;
        shadow_d   = shadow_q;
        enable_h_d = enable_h_q;
        hld_h_n_d  = hld_h_n_q;
        hld_ovr_d  = hld_ovr_q;
        out_d      = out_q;
        hold_ack_d = hold_ack_q;
        cfg_err_d  = 1'b0;

        if (state_q inside {StActive, StTri, StApply, StRelease}) begin
            out_d = out_req_i;
        end

        // Output registers are loaded on the same edge as the state transition they belong to.
        unique case (state_q)
            StOff: begin
                if (en_req_i) begin
                    state_d    = StEnabling;
                    cnt_d      = EnableLd;
                    enable_h_d = 1'b1;
                end
            end
            StEnabling: begin
                if (timer_done) state_d = StActive;
            end
            StActive: begin
                if (!en_req_i) begin
                    state_d       = StDisabling;
                    cnt_d         = SettleLd;
                    pad_d.oe_n    = 1'b1;
                    pad_d.dm      = 3'b000;
                    pad_d.inp_dis = 1'b1;
                end else if (hold_req_i) begin
                    state_d = StHoldSetup;
                    cnt_d   = SettleLd;
                end else if (cfg_io.valid) begin
                    if (cfg_legal) begin
                        shadow_d   = cfg_in;
                        state_d    = StTri;
                        cnt_d      = SettleLd;
                        pad_d.oe_n = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StTri: begin
                if (timer_done) begin
                    state_d    = StApply;
                    cnt_d      = SettleLd;
                    pad_d      = shadow_q;
                    pad_d.oe_n = 1'b1;
                end
            end
            StApply: begin
                if (timer_done) begin
                    state_d    = StRelease;
                    pad_d.oe_n = shadow_q.oe_n;
                end
            end
            StRelease: begin
                state_d = StActive;
            end
            StHoldSetup: begin
                if (timer_done) begin
                    state_d    = StHold;
                    hld_h_n_d  = 1'b0;
                    hold_ack_d = 1'b1;
                end
            end
            StHold: begin
                hld_ovr_d = hold_ovr_req_i;
                if (hld_ovr_q) out_d = out_req_i;
                if (!hold_req_i) begin
                    state_d   = StHoldExit;
                    cnt_d     = SettleLd;
                    hld_ovr_d = 1'b0;
                    pad_d     = shadow_q;
                    out_d     = out_req_i;
                end
            end
            StHoldExit: begin
                if (timer_done) begin
                    state_d    = StActive;
                    hld_h_n_d  = 1'b1;
                    hold_ack_d = 1'b0;
                end
            end
            StDisabling: begin
                if (timer_done) begin
                    state_d    = StOff;
                    enable_h_d = 1'b0;
                    pad_d      = SafeCfg;
                    shadow_d   = SafeCfg;
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StOff;
            cnt_q      <= 8'd0;
            pad_q      <= SafeCfg;
            shadow_q   <= SafeCfg;
            enable_h_q <= 1'b0;
            hld_h_n_q  <= 1'b1;
            hld_ovr_q  <= 1'b0;
            out_q      <= 1'b0;
            hold_ack_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pad_q      <= pad_d;
            shadow_q   <= shadow_d;
            enable_h_q <= enable_h_d;
            hld_h_n_q  <= hld_h_n_d;
            hld_ovr_q  <= hld_ovr_d;
            out_q      <= out_d;
            hold_ack_q <= hold_ack_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign enable_h_o  = enable_h_q;
    assign hld_h_n_o   = hld_h_n_q;
    assign hld_ovr_o   = hld_ovr_q;
    assign dm_o        = pad_q.dm;
    assign oe_n_o      = pad_q.oe_n;
    assign out_o       = out_q;
    assign slow_o      = pad_q.slow;
    assign vtrip_sel_o = pad_q.vtrip_sel;
    assign inp_dis_o   = pad_q.inp_dis;
    assign ibuf_sel_o  = pad_q.ibuf_sel;
    assign vreg_en_o   = pad_q.vreg_en;
    assign hold_ack_o  = hold_ack_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_sky130_fd_io__sio_cfg_seq.sv
// Directed bench for the SIO pad sequencer with SETTLE_CYC=4, ENABLE_CYC=8.
module tb_sky130_fd_io__sio_cfg_seq;

    logic       clk;
    logic       rst;
    logic       en_req, ref_good, out_req, hold_req, hold_ovr_req;
    logic       enable_h, hld_h_n, hld_ovr, oe_n, out, slow, vtrip_sel, inp_dis, ibuf_sel;
    logic       vreg_en, hold_ack, cfg_err, busy;
    logic [2:0] dm;
    int         total = 0;
    int         bad = 0;

    sky130_fd_io__sio_cfg_seq_if cfg_bus ();

    sky130_fd_io__sio_cfg_seq #(
        .SETTLE_CYC (4),
        .ENABLE_CYC (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_io         (cfg_bus),
        .en_req_i       (en_req),
        .ref_good_i     (ref_good),
        .out_req_i      (out_req),
        .hold_req_i     (hold_req),
        .hold_ovr_req_i (hold_ovr_req),
        .enable_h_o     (enable_h),
        .hld_h_n_o      (hld_h_n),
        .hld_ovr_o      (hld_ovr),
        .dm_o           (dm),
        .oe_n_o         (oe_n),
        .out_o          (out),
        .slow_o         (slow),
        .vtrip_sel_o    (vtrip_sel),
        .inp_dis_o      (inp_dis),
        .ibuf_sel_o     (ibuf_sel),
        .vreg_en_o      (vreg_en),
        .hold_ack_o     (hold_ack),
        .cfg_err_o      (cfg_err),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_enable_h"}, enable_h, 1'b0);
        chk1({tag, "_hld_h_n"}, hld_h_n, 1'b1);
        chk1({tag, "_hld_ovr"}, hld_ovr, 1'b0);
        chk3({tag, "_dm"}, dm, 3'b000);
        chk1({tag, "_oe_n"}, oe_n, 1'b1);
        chk1({tag, "_out"}, out, 1'b0);
        chk1({tag, "_slow"}, slow, 1'b0);
        chk1({tag, "_vtrip"}, vtrip_sel, 1'b0);
        chk1({tag, "_inp_dis"}, inp_dis, 1'b1);
        chk1({tag, "_ibuf"}, ibuf_sel, 1'b0);
        chk1({tag, "_vreg"}, vreg_en, 1'b0);
        chk1({tag, "_hold_ack"}, hold_ack, 1'b0);
        chk1({tag, "_cfg_err"}, cfg_err, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic set_cfg(input logic [2:0] d, input logic o, input logic s, input logic v,
                           input logic i, input logic b, input logic r);
        cfg_bus.valid     = 1'b1;
        cfg_bus.dm        = d;
        cfg_bus.oe_n      = o;
        cfg_bus.slow      = s;
        cfg_bus.vtrip_sel = v;
        cfg_bus.inp_dis   = i;
        cfg_bus.ibuf_sel  = b;
        cfg_bus.vreg_en   = r;
    endtask

    task automatic cfg_idle();
        set_cfg(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cfg_bus.valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_req = 1'b0; ref_good = 1'b0; out_req = 1'b0;
        hold_req = 1'b0; hold_ovr_req = 1'b0;
        cfg_idle();

        // Power-up
        tick(1);
        chk_reset("por");
        chk1("por_ready", cfg_bus.ready, 1'b0);
        rst = 1'b0;
        tick(1);
        en_req = 1'b1;
        tick(1);
        chk1("en_enable_h", enable_h, 1'b1);
        chk1("en_busy", busy, 1'b1);
        chk3("en_dm", dm, 3'b000);
        chk1("en_oe_n", oe_n, 1'b1);
        chk1("en_ready_lo", cfg_bus.ready, 1'b0);
        tick(7);
        chk1("en_ready_early", cfg_bus.ready, 1'b0);
        tick(1);
        chk1("en_ready", cfg_bus.ready, 1'b1);
        chk1("en_busy_done", busy, 1'b0);
        chk1("en_oe_n_done", oe_n, 1'b1);

        // Legal regulated config, accepted at edge t
        set_cfg(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        ref_good = 1'b1;
        tick(1);
        cfg_idle();
        chk1("cfg_tri_oe_n", oe_n, 1'b1);
        chk1("cfg_tri_ready", cfg_bus.ready, 1'b0);
        chk1("cfg_tri_busy", busy, 1'b1);
        chk3("cfg_tri_dm", dm, 3'b000);
        tick(3);
        chk3("cfg_tri_end_dm", dm, 3'b000);
        tick(1);
        chk3("cfg_apply_dm", dm, 3'b110);
        chk1("cfg_apply_vreg", vreg_en, 1'b1);
        chk1("cfg_apply_slow", slow, 1'b1);
        chk1("cfg_apply_ibuf", ibuf_sel, 1'b1);
        chk1("cfg_apply_inp_dis", inp_dis, 1'b0);
        chk1("cfg_apply_oe_n", oe_n, 1'b1);
        tick(3);
        chk1("cfg_apply_end_oe_n", oe_n, 1'b1);
        tick(1);
        chk1("cfg_release_oe_n", oe_n, 1'b0);
        chk1("cfg_release_ready", cfg_bus.ready, 1'b0);
        tick(1);
        chk1("cfg_done_ready", cfg_bus.ready, 1'b1);
        chk1("cfg_done_busy", busy, 1'b0);
        out_req = 1'b1;
        tick(1);
        chk1("active_out", out, 1'b1);

        // Illegal: unsupported drive mode with regulator on
        set_cfg(3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        chk1("ill1_err", cfg_err, 1'b1);
        chk3("ill1_dm", dm, 3'b110);
        chk1("ill1_oe_n", oe_n, 1'b0);
        chk1("ill1_ready", cfg_bus.ready, 1'b1);
        cfg_idle();
        tick(1);
        chk1("ill1_err_pulse", cfg_err, 1'b0);
        chk1("ill1_busy", busy, 1'b0);

        // Illegal: supported mode but reference not good
        set_cfg(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        ref_good = 1'b0;
        tick(1);
        chk1("ill2_err", cfg_err, 1'b1);
        chk3("ill2_dm", dm, 3'b110);
        chk1("ill2_ready", cfg_bus.ready, 1'b1);
        cfg_idle();
        ref_good = 1'b1;
        tick(1);
        chk1("ill2_err_pulse", cfg_err, 1'b0);

        // Hold entry
        hold_req = 1'b1;
        #1;
        chk1("hold_req_ready", cfg_bus.ready, 1'b0);
        tick(1);
        chk1("hsetup_busy", busy, 1'b1);
        chk1("hsetup_hld_h_n", hld_h_n, 1'b1);
        tick(3);
        chk1("hsetup_end_hld_h_n", hld_h_n, 1'b1);
        tick(1);
        chk1("hold_hld_h_n", hld_h_n, 1'b0);
        chk1("hold_ack", hold_ack, 1'b1);
        chk1("hold_busy", busy, 1'b0);
        out_req = 1'b0;
        tick(1);
        chk1("hold_out_frozen", out, 1'b1);
        hold_ovr_req = 1'b1;
        tick(1);
        chk1("hold_ovr_on", hld_ovr, 1'b1);
        chk1("hold_ovr_out_lag", out, 1'b1);
        tick(1);
        chk1("hold_ovr_out0", out, 1'b0);
        out_req = 1'b1;
        tick(1);
        chk1("hold_ovr_out1", out, 1'b1);
        hold_ovr_req = 1'b0;
        out_req = 1'b0;
        tick(1);
        chk1("hold_ovr_off", hld_ovr, 1'b0);
        chk1("hold_ovr_last_out", out, 1'b0);
        out_req = 1'b1;
        tick(1);
        chk1("hold_out_frozen2", out, 1'b0);
        en_req = 1'b0;
        set_cfg(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk1("hold_ign_enable_h", enable_h, 1'b1);
        chk1("hold_ign_ack", hold_ack, 1'b1);
        chk1("hold_ign_busy", busy, 1'b0);
        chk1("hold_ign_ready", cfg_bus.ready, 1'b0);
        chk3("hold_ign_dm", dm, 3'b110);
        en_req = 1'b1;
        cfg_idle();

        // Hold exit
        hold_req = 1'b0;
        tick(1);
        chk1("hexit_busy", busy, 1'b1);
        chk1("hexit_hld_h_n", hld_h_n, 1'b0);
        chk1("hexit_out", out, 1'b1);
        tick(3);
        chk1("hexit_end_hld_h_n", hld_h_n, 1'b0);
        tick(1);
        chk1("hexit_done_hld_h_n", hld_h_n, 1'b1);
        chk1("hexit_done_ack", hold_ack, 1'b0);
        chk1("hexit_done_ready", cfg_bus.ready, 1'b1);
        chk3("hexit_done_dm", dm, 3'b110);
        chk1("hexit_done_oe_n", oe_n, 1'b0);

        // Disable requested mid-configuration
        set_cfg(3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        cfg_idle();
        tick(4);
        chk3("dis_apply_dm", dm, 3'b101);
        chk1("dis_apply_vtrip", vtrip_sel, 1'b1);
        en_req = 1'b0;
        tick(3);
        chk1("dis_apply_oe_n", oe_n, 1'b1);
        tick(1);
        chk1("dis_release_oe_n", oe_n, 1'b0);
        tick(1);
        chk1("dis_active_busy", busy, 1'b0);
        chk1("dis_active_ready", cfg_bus.ready, 1'b0);
        tick(1);
        chk1("dis_oe_n", oe_n, 1'b1);
        chk3("dis_dm", dm, 3'b000);
        chk1("dis_inp_dis", inp_dis, 1'b1);
        chk1("dis_busy", busy, 1'b1);
        tick(3);
        chk1("dis_end_enable_h", enable_h, 1'b1);
        tick(1);
        chk1("off_enable_h", enable_h, 1'b0);
        chk1("off_busy", busy, 1'b0);
        chk1("off_vreg", vreg_en, 1'b0);

        // Reset during TRI
        en_req = 1'b1;
        tick(9);
        chk1("re_ready", cfg_bus.ready, 1'b1);
        set_cfg(3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);
        cfg_idle();
        chk1("rst_tri_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        chk_reset("rst_tri");
        rst = 1'b0;
        tick(1);
        chk1("rst_tri_reenable", enable_h, 1'b1);

        // Reset during HOLD
        tick(8);
        hold_req = 1'b1;
        tick(5);
        chk1("rst_hold_ack_pre", hold_ack, 1'b1);
        chk1("rst_hold_hld_h_n_pre", hld_h_n, 1'b0);
        hold_ovr_req = 1'b1;
        tick(1);
        chk1("rst_hold_ovr_pre", hld_ovr, 1'b1);
        rst = 1'b1;
        tick(1);
        chk_reset("rst_hold");
        rst = 1'b0;
        en_req = 1'b0;
        hold_req = 1'b0;
        hold_ovr_req = 1'b0;
        tick(1);
        chk1("rst_hold_stay_off", enable_h, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
